syn_co_param: RTL and testbench

Parametrised synchronous up/down counter. It is the next generation of the team's fixed 3-bit free-running counter.
- Adds configurable width and modulus, count enable, direction control, parallel load, and wrap or saturate mode.
- Adds a registered wrap pulse, a sticky overflow flag and a Gray-coded output.
- Used as a general event and timebase counter in datapath and control blocks.

---
 rtl/syn_co_param_if.sv | 25 ++
 rtl/syn_co_param.sv | 89 ++++++++
 tb/tb_syn_co_param.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/syn_co_param_if.sv
// Control and status bundle for the parametrised up/down counter.
// The counter sits on the slave side; the controlling block drives the master side.
interface syn_co_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up_dn, load, load_val, clr_ovf,
    input  q, gray_q, wrap, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, clr_ovf,
    output q, gray_q, wrap, ovf
  );
endinterface

// File: rtl/syn_co_param.sv
// Parametrised synchronous up/down counter with load, wrap/saturate mode,
// registered wrap pulse, sticky overflow flag and registered Gray output.
module syn_co_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  syn_co_param_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;
  logic             ovf_r;

  logic [WIDTH-1:0] q_nxt;
  logic             evt;
  logic             ovf_nxt;
  logic             at_max;
  logic             at_zero;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  assign at_max  = (q_r == MAX_VAL);
  assign at_zero = (q_r == '0);

  // Priority: load, then count, then hold. An event is any count attempt
  // at a range end, whether the counter then wraps or saturates.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    q_nxt = q_r;
    evt   = 1'b0;
    if (bus.load) begin
      q_nxt = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_max) begin
          evt   = 1'b1;
          q_nxt = SATURATE ? MAX_VAL : '0;
        end else begin
          q_nxt = q_r + 1'b1;
        end
      end else begin
        if (at_zero) begin
          evt   = 1'b1;
          q_nxt = SATURATE ? '0 : MAX_VAL;
        end else begin
          q_nxt = q_r - 1'b1;
        end
      end
    end
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    ovf_nxt = ovf_r;
    if (evt) begin
      ovf_nxt = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_nxt = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r    <= RESET_VAL;
      gray_r <= to_gray(RESET_VAL);
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      gray_r <= to_gray(q_nxt);
      wrap_r <= evt;
      ovf_r  <= ovf_nxt;
    end
  end

  assign bus.q      = q_r;
  assign bus.gray_q = gray_r;
  assign bus.wrap   = wrap_r;
  assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_syn_co_param.sv
// Self-checking bench for syn_co_param: five parameter sets, table-driven
// vectors plus looped sequences, expected values queued and checked one cycle later.
module tb_syn_co_param;

  typedef struct {
    string       name;
    int          d;
    bit          rst_n;
    bit          en;
    bit          up;
    bit          ld;
    logic [31:0] lv;
    bit          clr;
    logic [31:0] q;
    bit          wrap;
    bit          ovf;
    int          seq;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] g;
    logic        wrap;
    logic        ovf;
  } obs_t;

  logic       clk;
  logic [4:0] rst_v;
  int         n_checks;
  int         n_fail;
  int         seq_no;
  vec_t       tbl[$];
  vec_t       sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  syn_co_param_if #(.WIDTH(8)) if0 ();
  syn_co_param_if #(.WIDTH(4)) if1 ();
  syn_co_param_if #(.WIDTH(4)) if2 ();
  syn_co_param_if #(.WIDTH(4)) if3 ();
  syn_co_param_if #(.WIDTH(3)) if4 ();

  // d0: default 8-bit modular counter
  syn_co_param #(.WIDTH(8), .MAX_VAL(8'd255), .SATURATE(1'b0), .RESET_VAL(8'd0))
    u0 (.clk(clk), .rst(rst_v[0]), .bus(if0.slave));
  // d1: modulus-10 wrapping counter
  syn_co_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0))
    u1 (.clk(clk), .rst(rst_v[1]), .bus(if1.slave));
  // d2: saturating 0..12 counter
  syn_co_param #(.WIDTH(4), .MAX_VAL(4'd12), .SATURATE(1'b1), .RESET_VAL(4'd0))
    u2 (.clk(clk), .rst(rst_v[2]), .bus(if2.slave));
  // d3: modulus-10 counter with non-zero reset value
  syn_co_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd3))
    u3 (.clk(clk), .rst(rst_v[3]), .bus(if3.slave));
  // d4: full-range 3-bit counter
  syn_co_param #(.WIDTH(3), .MAX_VAL(3'd7), .SATURATE(1'b0), .RESET_VAL(3'd0))
    u4 (.clk(clk), .rst(rst_v[4]), .bus(if4.slave));

  function automatic vec_t mk(input string name, input int d, input bit rst_n,
                              input bit en, input bit up, input bit ld,
                              input logic [31:0] lv, input bit clr,
                              input logic [31:0] q, input bit wrap, input bit ovf);
    vec_t v;
    v.name  = name;
    v.d     = d;
    v.rst_n = rst_n;
    v.en    = en;
    v.up    = up;
    v.ld    = ld;
    v.lv    = lv;
    v.clr   = clr;
    v.q     = q;
    v.wrap  = wrap;
    v.ovf   = ovf;
    v.seq   = 0;
    return v;
  endfunction

  task automatic add(input string name, input int d, input bit rst_n, input bit en,
                     input bit up, input bit ld, input logic [31:0] lv, input bit clr,
                     input logic [31:0] q, input bit wrap, input bit ovf);
    tbl.push_back(mk(name, d, rst_n, en, up, ld, lv, clr, q, wrap, ovf));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic obs_t observe(input int d);
    obs_t o;
    o.q = '0; o.g = '0; o.wrap = 1'b0; o.ovf = 1'b0;
    case (d)
      0: begin o.q = 32'(if0.q); o.g = 32'(if0.gray_q); o.wrap = if0.wrap; o.ovf = if0.ovf; end
      1: begin o.q = 32'(if1.q); o.g = 32'(if1.gray_q); o.wrap = if1.wrap; o.ovf = if1.ovf; end
      2: begin o.q = 32'(if2.q); o.g = 32'(if2.gray_q); o.wrap = if2.wrap; o.ovf = if2.ovf; end
      3: begin o.q = 32'(if3.q); o.g = 32'(if3.gray_q); o.wrap = if3.wrap; o.ovf = if3.ovf; end
      default: begin o.q = 32'(if4.q); o.g = 32'(if4.gray_q); o.wrap = if4.wrap; o.ovf = if4.ovf; end
    endcase
    return o;
  endfunction

  task automatic drive(input vec_t v);
    case (v.d)
      0: begin rst_v[0] = v.rst_n; if0.en = v.en; if0.up_dn = v.up; if0.load = v.ld;
               if0.load_val = v.lv[7:0]; if0.clr_ovf = v.clr; end
      1: begin rst_v[1] = v.rst_n; if1.en = v.en; if1.up_dn = v.up; if1.load = v.ld;
               if1.load_val = v.lv[3:0]; if1.clr_ovf = v.clr; end
      2: begin rst_v[2] = v.rst_n; if2.en = v.en; if2.up_dn = v.up; if2.load = v.ld;
               if2.load_val = v.lv[3:0]; if2.clr_ovf = v.clr; end
      3: begin rst_v[3] = v.rst_n; if3.en = v.en; if3.up_dn = v.up; if3.load = v.ld;
               if3.load_val = v.lv[3:0]; if3.clr_ovf = v.clr; end
      default: begin rst_v[4] = v.rst_n; if4.en = v.en; if4.up_dn = v.up; if4.load = v.ld;
               if4.load_val = v.lv[2:0]; if4.clr_ovf = v.clr; end
    endcase
  endtask

  task automatic compare(input vec_t e);
    obs_t  o;
    string tag;
    o   = observe(e.d);
    tag = $sformatf("%s#%0d(d%0d)", e.name, e.seq, e.d);
    check({tag, ".q"},      o.q,           e.q);
    check({tag, ".gray_q"}, o.g,           e.q ^ (e.q >> 1));
    check({tag, ".wrap"},   32'(o.wrap),   32'(e.wrap));
    check({tag, ".ovf"},    32'(o.ovf),    32'(e.ovf));
  endtask

  // Outputs of the previous edge are compared at the negedge, then the next
  // stimulus is driven and its expectation queued for the following negedge.
  task automatic step(input vec_t v);
    @(negedge clk);
    if (sb.size() > 0) compare(sb.pop_front());
    drive(v);
    seq_no++;
    v.seq = seq_no;
    sb.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    seq_no   = 0;
    rst_v    = '0;
    if0.en = 0; if0.up_dn = 0; if0.load = 0; if0.load_val = '0; if0.clr_ovf = 0;
    if1.en = 0; if1.up_dn = 0; if1.load = 0; if1.load_val = '0; if1.clr_ovf = 0;
    if2.en = 0; if2.up_dn = 0; if2.load = 0; if2.load_val = '0; if2.clr_ovf = 0;
    if3.en = 0; if3.up_dn = 0; if3.load = 0; if3.load_val = '0; if3.clr_ovf = 0;
    if4.en = 0; if4.up_dn = 0; if4.load = 0; if4.load_val = '0; if4.clr_ovf = 0;

    // Load priority and clamp on the modulus-10 counter (continues from q=9).
    add("ld_en",    1, 1, 1, 1, 1, 5,  0, 5, 0, 0);
    add("ld_clamp", 1, 1, 1, 0, 1, 14, 0, 9, 0, 0);
    add("hold",     1, 1, 0, 1, 0, 0,  0, 9, 0, 0);
    add("hold",     1, 1, 0, 0, 0, 0,  0, 9, 0, 0);
    add("hold",     1, 1, 0, 1, 0, 0,  0, 9, 0, 0);
    add("ld_zero",  1, 1, 0, 0, 1, 0,  0, 0, 0, 0);
    add("up_mid",   1, 1, 1, 1, 0, 0,  0, 1, 0, 0);
    // Saturating counter at both ends; clr_ovf loses against an event.
    add("sat_rst",  2, 0, 0, 0, 0, 0,  0, 0,  0, 0);
    add("sat_ld",   2, 1, 0, 0, 1, 10, 0, 10, 0, 0);
    add("sat_up",   2, 1, 1, 1, 0, 0,  0, 11, 0, 0);
    add("sat_up",   2, 1, 1, 1, 0, 0,  0, 12, 0, 0);
    add("sat_top",  2, 1, 1, 1, 0, 0,  0, 12, 1, 1);
    add("sat_clr",  2, 1, 1, 1, 0, 0,  1, 12, 1, 1);
    add("sat_clr",  2, 1, 1, 1, 0, 0,  1, 12, 1, 1);
    add("sat_idle", 2, 1, 0, 1, 0, 0,  1, 12, 0, 0);
    add("sat_ld0",  2, 1, 0, 0, 1, 0,  0, 0,  0, 0);
    add("sat_bot",  2, 1, 1, 0, 0, 0,  0, 0,  1, 1);
    add("sat_rise", 2, 1, 1, 1, 0, 0,  0, 1,  0, 1);
    // Reset overriding load and count, RESET_VAL=3.
    add("rv_rst",   3, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    add("rv_ld",    3, 1, 0, 0, 1, 9, 0, 9, 0, 0);
    add("rv_wrap",  3, 1, 1, 1, 0, 0, 0, 0, 1, 1);
    add("rv_ld6",   3, 1, 1, 1, 1, 6, 0, 6, 0, 1);
    add("rv_up",    3, 1, 1, 1, 0, 0, 0, 7, 0, 1);
    add("rv_ovr",   3, 0, 1, 1, 1, 8, 0, 3, 0, 0);
    add("rv_run",   3, 1, 1, 1, 0, 0, 0, 4, 0, 0);
    add("rv_run",   3, 1, 1, 1, 0, 0, 0, 5, 0, 0);
    // Direction toggling at the modular boundary of the 3-bit counter.
    add("dir_rst",  4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("dir_ld",   4, 1, 0, 0, 1, 7, 0, 7, 0, 0);
    add("dir_up",   4, 1, 1, 1, 0, 0, 0, 0, 1, 1);
    add("dir_dn",   4, 1, 1, 0, 0, 0, 0, 7, 1, 1);
    add("dir_up",   4, 1, 1, 1, 0, 0, 0, 0, 1, 1);
    add("dir_hold", 4, 1, 0, 1, 0, 0, 0, 0, 0, 1);

    // Full-range 8-bit run: two reset cycles then 258 up counts.
    for (int i = 0; i < 2; i++)
      step(mk("cnt8_rst", 0, 0, 1, 1, 1, 77, 0, 0, 0, 0));
    for (int i = 1; i <= 258; i++)
      step(mk("cnt8", 0, 1, 1, 1, 0, 0, 0, 32'(i % 256), i == 256, i >= 256));

    // Modulus-10 down count from 0 through two underflows, then clear ovf.
    step(mk("mod10_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 11; k++)
      step(mk("mod10_dn", 1, 1, 1, 0, 0, 0, 0, 32'((10 - (k % 10)) % 10), (k % 10) == 1, 1));
    step(mk("mod10_clr", 1, 1, 0, 0, 0, 0, 1, 9, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    @(negedge clk);
    if (sb.size() > 0) compare(sb.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
